// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one single-port synchronous character RAM between
// the VGA text fetch (one read every 8 visible pixels, absolute priority) and
// a CPU port with a req/ack handshake.
// Optional build macro: VGA_ARB_STATS_EN adds a saturating CPU stall counter;
// without it conflict_cnt_o is tied to zero.
module vga_mem_arbiter #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int COLS      = 80,
    parameter int MEM_DEPTH = 2400
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [9:0]  h_count_i,
    input  logic [9:0]  v_count_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [11:0] cpu_addr_i,
    input  logic [7:0]  cpu_wdata_i,
    output logic        cpu_ack_o,
    output logic [7:0]  cpu_rdata_o,
    output logic [11:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    output logic [7:0]  char_o,
    output logic        char_valid_o,
    output logic [15:0] conflict_cnt_o
);

    localparam logic [10:0] H_VIS_W = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_W = 11'(V_VISIBLE);
    localparam logic [11:0] COLS_W  = 12'(COLS);
    localparam logic [12:0] DEPTH_W = 13'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RD  = 2'd1,
        CPU_ACK = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        slot;
    logic        grant;
    logic        addr_ok;
    logic        rd_oor_q;
    logic        slot_q;
    logic [11:0] slot_addr;
    logic [7:0]  rdata_q;
    logic [7:0]  char_q;
    logic [7:0]  rd_value;

    // A slot is the first pixel of each visible character cell.
    assign slot = (h_count_i[2:0] == 3'd0)
               && ({1'b0, h_count_i} < H_VIS_W)
               && ({1'b0, v_count_i} < V_VIS_W);

    // Character cell index: text row (16 lines per row) times COLS plus column.
    assign slot_addr = 12'(v_count_i[9:4]) * COLS_W + 12'(h_count_i[9:3]);

    assign addr_ok = ({1'b0, cpu_addr_i} < DEPTH_W);

    // Next-state logic: CPU is granted only from IDLE and only outside a slot.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i && !slot) begin
                    grant   = 1'b1;
                    state_d = cpu_we_i ? CPU_ACK : CPU_RD;
                end
            end
            CPU_RD:  state_d = IDLE;
            CPU_ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM port mux: CPU address only in a grant cycle, otherwise the slot address.
    always_comb begin
        mem_addr_o  = grant ? cpu_addr_i : slot_addr;
        mem_we_o    = grant && cpu_we_i && addr_ok && reset_n_i;
        mem_wdata_o = cpu_wdata_i;
    end

    // Out-of-range reads return zero instead of whatever the RAM produced.
    assign rd_value    = rd_oor_q ? 8'h00 : mem_rdata_i;
    assign cpu_ack_o   = (state_q == CPU_RD) || (state_q == CPU_ACK);
    assign cpu_rdata_o = (state_q == CPU_RD) ? rd_value : rdata_q;
    assign char_valid_o = slot_q;
    assign char_o       = slot_q ? mem_rdata_i : char_q;

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Remember whether the granted access was out of range for the read return.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_oor_q <= 1'b0;
        end else if (grant) begin
            rd_oor_q <= !addr_ok;
        end
    end

    // Hold the last CPU read data after its ack cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rdata_q <= 8'h00;
        end else if (state_q == CPU_RD) begin
            rdata_q <= rd_value;
        end
    end

    // Track the slot one cycle back so the fetched character can be presented.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            slot_q <= 1'b0;
            char_q <= 8'h00;
        end else begin
            slot_q <= slot;
            if (slot_q) begin
                char_q <= mem_rdata_i;
            end
        end
    end

`ifdef VGA_ARB_STATS_EN
    logic        stall;
    logic [15:0] conflict_q;

    assign stall = (state_q == IDLE) && cpu_req_i && slot;

    // Count cycles in which a CPU request lost to a VGA slot, saturating.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            conflict_q <= 16'h0000;
        end else if (stall && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cnt_o = conflict_q;
`else
    assign conflict_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: directed bench for vga_mem_arbiter with a behavioural
// single-port synchronous RAM attached to the memory port.
module tb_vga_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  char_out;
    logic        char_valid;
    logic [15:0] conflict_cnt;

    int n_compared;
    int n_mismatched;

    logic [7:0] ram [0:4095];

    vga_mem_arbiter dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .h_count_i      (h_count),
        .v_count_i      (v_count),
        .cpu_req_i      (cpu_req),
        .cpu_we_i       (cpu_we),
        .cpu_addr_i     (cpu_addr),
        .cpu_wdata_i    (cpu_wdata),
        .cpu_ack_o      (cpu_ack),
        .cpu_rdata_o    (cpu_rdata),
        .mem_addr_o     (mem_addr),
        .mem_we_o       (mem_we),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .char_o         (char_out),
        .char_valid_o   (char_valid),
        .conflict_cnt_o (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Initial RAM contents pattern.
    function automatic logic [7:0] pat(input int i);
        return 8'(i) ^ 8'h3C;
    endfunction

    // Synchronous single-port RAM model, read-before-write.
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = pat(i);
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            mem_rdata <= ram[mem_addr];
            if (mem_we) ram[mem_addr] <= mem_wdata;
        end
    end

    // Drive one cycle of inputs at the falling edge; checks follow 1 ns later.
    task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic req,
                         input logic we, input logic [11:0] addr, input logic [7:0] wd);
        @(negedge clk);
        h_count   = h;
        v_count   = v;
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(10'd1, 10'd0, 1'b1, 1'b1, 12'd5, 8'h11);
        n_compared++; if (cpu_ack !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_ack: got %b want 0", cpu_ack); end
        n_compared++; if (cpu_rdata !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_rdata: got %h want 00", cpu_rdata); end
        n_compared++; if (char_out !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_char: got %h want 00", char_out); end
        n_compared++; if (char_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_char_valid: got %b want 0", char_valid); end
        n_compared++; if (conflict_cnt !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL reset_conflict: got %h want 0000", conflict_cnt); end
        n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we); end
        drive(10'd1, 10'd0, 1'b0, 1'b0, 12'd0, 8'h00);
        reset_n = 1'b1;
    endtask

    task automatic test_slot_fetch();
        drive(10'd0, 10'd0, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (mem_addr !== 12'd0) begin n_mismatched++; $display("[TB] FAIL slot0_addr: got %0d want 0", mem_addr); end
        n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL slot0_we: got %b want 0", mem_we); end
        drive(10'd1, 10'd0, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (char_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL slot0_valid: got %b want 1", char_valid); end
        n_compared++; if (char_out !== pat(0)) begin n_mismatched++; $display("[TB] FAIL slot0_char: got %h want %h", char_out, pat(0)); end
        drive(10'd2, 10'd0, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (char_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL slot0_valid_pulse: got %b want 0", char_valid); end
        n_compared++; if (char_out !== pat(0)) begin n_mismatched++; $display("[TB] FAIL slot0_char_hold: got %h want %h", char_out, pat(0)); end
        drive(10'd16, 10'd16, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (mem_addr !== 12'd82) begin n_mismatched++; $display("[TB] FAIL slot_row1_addr: got %0d want 82", mem_addr); end
    endtask

    task automatic test_boundary();
        drive(10'd632, 10'd479, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (mem_addr !== 12'd2399) begin n_mismatched++; $display("[TB] FAIL last_slot_addr: got %0d want 2399", mem_addr); end
        drive(10'd633, 10'd479, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (char_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL last_slot_valid: got %b want 1", char_valid); end
        n_compared++; if (char_out !== pat(2399)) begin n_mismatched++; $display("[TB] FAIL last_slot_char: got %h want %h", char_out, pat(2399)); end
        drive(10'd640, 10'd0, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hblank_we: got %b want 0", mem_we); end
        drive(10'd641, 10'd0, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (char_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hblank_valid: got %b want 0", char_valid); end
        drive(10'd0, 10'd480, 1'b0, 1'b0, 12'd0, 8'h00);
        drive(10'd1, 10'd480, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (char_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL vblank_valid: got %b want 0", char_valid); end
    endtask

    task automatic test_cpu_write_read();
        drive(10'd1, 10'd0, 1'b1, 1'b1, 12'd5, 8'hA5);
        n_compared++; if (mem_we !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wr_mem_we: got %b want 1", mem_we); end
        n_compared++; if (mem_addr !== 12'd5) begin n_mismatched++; $display("[TB] FAIL wr_mem_addr: got %0d want 5", mem_addr); end
        n_compared++; if (mem_wdata !== 8'hA5) begin n_mismatched++; $display("[TB] FAIL wr_mem_wdata: got %h want a5", mem_wdata); end
        n_compared++; if (cpu_ack !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wr_early_ack: got %b want 0", cpu_ack); end
        drive(10'd2, 10'd0, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (cpu_ack !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wr_ack: got %b want 1", cpu_ack); end
        n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wr_ack_we: got %b want 0", mem_we); end
        drive(10'd3, 10'd0, 1'b1, 1'b0, 12'd5, 8'h00);
        n_compared++; if (cpu_ack !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wr_ack_pulse: got %b want 0", cpu_ack); end
        n_compared++; if (mem_addr !== 12'd5) begin n_mismatched++; $display("[TB] FAIL rd_mem_addr: got %0d want 5", mem_addr); end
        drive(10'd4, 10'd0, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (cpu_ack !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rd_ack: got %b want 1", cpu_ack); end
        n_compared++; if (cpu_rdata !== 8'hA5) begin n_mismatched++; $display("[TB] FAIL rd_data: got %h want a5", cpu_rdata); end
        drive(10'd5, 10'd0, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (cpu_rdata !== 8'hA5) begin n_mismatched++; $display("[TB] FAIL rd_data_hold: got %h want a5", cpu_rdata); end
    endtask

    task automatic test_stall();
        logic [15:0] exp_cnt;
`ifdef VGA_ARB_STATS_EN
        exp_cnt = 16'd1;
`else
        exp_cnt = 16'd0;
`endif
        drive(10'd8, 10'd0, 1'b1, 1'b1, 12'd7, 8'h5A);
        n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stall_we: got %b want 0", mem_we); end
        n_compared++; if (mem_addr !== 12'd1) begin n_mismatched++; $display("[TB] FAIL stall_slot_addr: got %0d want 1", mem_addr); end
        drive(10'd9, 10'd0, 1'b1, 1'b1, 12'd7, 8'h5A);
        n_compared++; if (mem_we !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stall_grant_we: got %b want 1", mem_we); end
        n_compared++; if (mem_addr !== 12'd7) begin n_mismatched++; $display("[TB] FAIL stall_grant_addr: got %0d want 7", mem_addr); end
        n_compared++; if (cpu_ack !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stall_early_ack: got %b want 0", cpu_ack); end
        n_compared++; if (char_out !== pat(1)) begin n_mismatched++; $display("[TB] FAIL stall_char: got %h want %h", char_out, pat(1)); end
        drive(10'd10, 10'd0, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (cpu_ack !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stall_ack: got %b want 1", cpu_ack); end
        n_compared++; if (conflict_cnt !== exp_cnt) begin n_mismatched++; $display("[TB] FAIL stall_conflict: got %0d want %0d", conflict_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        drive(10'd15, 10'd0, 1'b1, 1'b0, 12'd5, 8'h00);
        drive(10'd16, 10'd0, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (mem_addr !== 12'd2) begin n_mismatched++; $display("[TB] FAIL overlap_slot_addr: got %0d want 2", mem_addr); end
        n_compared++; if (cpu_ack !== 1'b1) begin n_mismatched++; $display("[TB] FAIL overlap_ack: got %b want 1", cpu_ack); end
        n_compared++; if (cpu_rdata !== 8'hA5) begin n_mismatched++; $display("[TB] FAIL overlap_rdata: got %h want a5", cpu_rdata); end
        drive(10'd17, 10'd0, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (char_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL overlap_valid: got %b want 1", char_valid); end
        n_compared++; if (char_out !== pat(2)) begin n_mismatched++; $display("[TB] FAIL overlap_char: got %h want %h", char_out, pat(2)); end
    endtask

    task automatic test_out_of_range();
        drive(10'd1, 10'd0, 1'b1, 1'b1, 12'd2400, 8'hFF);
        n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL oor_we: got %b want 0", mem_we); end
        drive(10'd2, 10'd0, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (cpu_ack !== 1'b1) begin n_mismatched++; $display("[TB] FAIL oor_wr_ack: got %b want 1", cpu_ack); end
        drive(10'd3, 10'd0, 1'b1, 1'b0, 12'd4095, 8'h00);
        drive(10'd4, 10'd0, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (cpu_ack !== 1'b1) begin n_mismatched++; $display("[TB] FAIL oor_rd_ack: got %b want 1", cpu_ack); end
        n_compared++; if (cpu_rdata !== 8'h00) begin n_mismatched++; $display("[TB] FAIL oor_rdata: got %h want 00", cpu_rdata); end
        n_compared++; if (ram[2400] !== pat(2400)) begin n_mismatched++; $display("[TB] FAIL oor_ram_intact: got %h want %h", ram[2400], pat(2400)); end
    endtask

    task automatic test_reset_mid_access();
        drive(10'd1, 10'd0, 1'b1, 1'b0, 12'd5, 8'h00);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_compared++; if (cpu_ack !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_reset_ack: got %b want 0", cpu_ack); end
        n_compared++; if (cpu_rdata !== 8'h00) begin n_mismatched++; $display("[TB] FAIL mid_reset_rdata: got %h want 00", cpu_rdata); end
        n_compared++; if (char_out !== 8'h00) begin n_mismatched++; $display("[TB] FAIL mid_reset_char: got %h want 00", char_out); end
        n_compared++; if (char_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_reset_valid: got %b want 0", char_valid); end
        n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_reset_we: got %b want 0", mem_we); end
        drive(10'd2, 10'd0, 1'b0, 1'b0, 12'd0, 8'h00);
        reset_n = 1'b1;
        drive(10'd3, 10'd0, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (cpu_ack !== 1'b0) begin n_mismatched++; $display("[TB] FAIL post_reset_no_ack: got %b want 0", cpu_ack); end
        drive(10'd3, 10'd0, 1'b1, 1'b1, 12'd9, 8'h33);
        n_compared++; if (mem_we !== 1'b1) begin n_mismatched++; $display("[TB] FAIL post_reset_grant: got %b want 1", mem_we); end
        drive(10'd4, 10'd0, 1'b0, 1'b0, 12'd0, 8'h00);
        n_compared++; if (cpu_ack !== 1'b1) begin n_mismatched++; $display("[TB] FAIL post_reset_ack: got %b want 1", cpu_ack); end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset_n   = 1'b0;
        h_count   = 10'd1;
        v_count   = 10'd0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 12'd0;
        cpu_wdata = 8'h00;
        test_reset();
        test_slot_fetch();
        test_boundary();
        test_cpu_write_read();
        test_stall();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
